// File: rtl/change_trace_buffer_pkg.sv
// change_trace_buffer_pkg: shared event-packing constants for the change trace buffer
package change_trace_buffer_pkg;
  localparam int DROP_CNT_W = 8;
  localparam int EV_VAL_LSB = 0;
  function automatic int ev_ts_lsb(input int width);
    return EV_VAL_LSB + width;
  endfunction
endpackage

// File: rtl/change_trace_buffer_trace_fifo.sv
// trace_fifo: single-clock FIFO; while empty the head holds the last popped entry
module trace_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W-1:0] last_q, last_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign rdata = empty ? last_q : mem_q[rd_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + (AW)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (AW)'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    last_d = do_pop ? mem_q[rd_q] : last_q;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/change_trace_buffer.sv
// change_trace_buffer: logs {timestamp, value} on every change of sample_in into a FIFO
// Optional drop_count port when TRACE_DROP_COUNT_EN is defined.
module change_trace_buffer
  import change_trace_buffer_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    sample_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic [WIDTH-1:0]    out_value,
  output logic [AW:0]         count,
  output logic                overflow
`ifdef TRACE_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);
  localparam int EV_TS_LSB = ev_ts_lsb(WIDTH);
  localparam int EV_W = TS_WIDTH + WIDTH;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic first_q, first_d, ovf_q, ovf_d;
  logic ev, drop, full, empty;
  logic [EV_W-1:0] ev_data, head;
  always_comb begin
    ev = enable && (first_q || sample_in != prev_q);
    drop = ev && full && !out_ready;
    ev_data = {ts_q, sample_in};
    ts_d = ts_q + (TS_WIDTH)'(1);
    prev_d = ev ? sample_in : prev_q;
    first_d = first_q && !ev;
    ovf_d = ovf_q || drop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
      prev_q <= '0;
      first_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      ts_q <= ts_d;
      prev_q <= prev_d;
      first_q <= first_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef TRACE_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  always_comb drop_d = (drop && drop_q != '1) ? drop_q + (DROP_CNT_W)'(1) : drop_q;
  always_ff @(posedge clk)
    if (rst) drop_q <= '0;
    else drop_q <= drop_d;
  assign drop_count = drop_q;
`endif
  trace_fifo #(.W(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(ev),
    .pop(out_valid && out_ready),
    .wdata(ev_data),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign out_valid = !empty;
  assign out_ts = head[EV_TS_LSB +: TS_WIDTH];
  assign out_value = head[EV_VAL_LSB +: WIDTH];
  assign overflow = ovf_q;
endmodule

// File: tb/tb_change_trace_buffer.sv
// tb_change_trace_buffer: directed stimulus with a queue scoreboard checked by a pop monitor
module tb_change_trace_buffer;
  logic clk, rst, enable, out_valid, out_ready, overflow;
  logic [2:0] sample_in, out_value, count;
  logic [15:0] out_ts;
`ifdef TRACE_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif
  logic [18:0] sb[$];
  logic [18:0] exp_ev;
  int checks = 0, errors = 0;

  change_trace_buffer #(.WIDTH(3), .TS_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
    .out_value(out_value), .count(count), .overflow(overflow)
`ifdef TRACE_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chg(input logic [2:0] v, input logic [15:0] t);
    sample_in = v;
    sb.push_back({t, v});
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got ts=%0d val=%b want none", out_ts, out_value);
      end else begin
        exp_ev = sb.pop_front();
        if ({out_ts, out_value} !== exp_ev) begin
          errors++;
          $display("FAIL pop_order got ts=%0d val=%b want ts=%0d val=%b",
                   out_ts, out_value, exp_ev[18:3], exp_ev[2:0]);
        end
      end
    end
  end

  initial begin
    rst = 1; enable = 1; sample_in = 3'b000; out_ready = 0;
    cyc(); cyc();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ts", out_ts, 0);
    chk("rst_value", out_value, 0);
    sb.push_back({16'd0, 3'b000});
    rst = 0;
    cyc();
    chk("t1_count", count, 1);
    chk("t1_valid", out_valid, 1);
    cyc();
    chk("t1_count_hold", count, 1);
    out_ready = 1;
    chg(3'b001, 16'd2); cyc();
    chk("t2_latency_ts", out_ts, 2);
    chg(3'b011, 16'd3); cyc();
    chg(3'b010, 16'd4); cyc();
    cyc();
    chk("t2_count", count, 0);
    chk("t2_overflow", overflow, 0);
    out_ready = 0;
    chg(3'b011, 16'd6); cyc();
    chg(3'b001, 16'd7); cyc();
    chg(3'b000, 16'd8); cyc();
    chg(3'b100, 16'd9); cyc();
    sample_in = 3'b101; cyc();
    sample_in = 3'b111; cyc();
    chk("t3_count", count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_head_ts", out_ts, 6);
`ifdef TRACE_DROP_COUNT_EN
    chk("t3_drop_count", drop_count, 2);
`endif
    out_ready = 1;
    repeat (4) cyc();
    chk("t3_prev_tracks_drop", count, 0);
    chk("t3_overflow_sticky", overflow, 1);
    out_ready = 0;
    rst = 1;
    sb.delete();
    cyc(); cyc();
    chk("rst2_overflow", overflow, 0);
    chk("rst2_count", count, 0);
`ifdef TRACE_DROP_COUNT_EN
    chk("rst2_drop_count", drop_count, 0);
`endif
    chg(3'b000, 16'd0);
    rst = 0;
    cyc();
    chg(3'b001, 16'd1); cyc();
    chg(3'b011, 16'd2); cyc();
    chg(3'b010, 16'd3); cyc();
    chk("t4_full_count", count, 4);
    out_ready = 1;
    chg(3'b110, 16'd4); cyc();
    chk("t4_count", count, 4);
    chk("t4_overflow", overflow, 0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", out_valid, 1);
      chk("t5_ts_stable", out_ts, 1);
      chk("t5_value_stable", out_value, 3'b001);
      cyc();
    end
    out_ready = 1;
    repeat (4) cyc();
    chk("t5_empty_valid", out_valid, 0);
    chk("t5_empty_count", count, 0);
    chk("t5_hold_ts", out_ts, 4);
    chk("t5_hold_value", out_value, 3'b110);
    out_ready = 0;
    chg(3'b111, 16'd14); cyc();
    chg(3'b101, 16'd15); cyc();
    chg(3'b100, 16'd16); cyc();
    chk("t6_count", count, 3);
    rst = 1;
    sb.delete();
    cyc();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_overflow", overflow, 0);
    cyc();
    sb.push_back({16'd0, 3'b100});
    rst = 0;
    out_ready = 1;
    cyc();
    chk("t6_first_ts", out_ts, 0);
    chk("t6_first_value", out_value, 3'b100);
    cyc();
    chk("t6_drained_count", count, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
